// File: rtl/core_pkg.sv
// Core-wide shared types: register bank select, write-back source tag and the
// LLU result entry queued by the write-port arbiter.
package core_pkg;

    typedef enum logic {
        X_REG = 1'b0,
        F_REG = 1'b1
    } reg_bank_mux_t;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_LLU  = 1'b1
    } wb_src_t;

    typedef struct packed {
        logic [4:0]    addr;
        reg_bank_mux_t bank;
        logic [31:0]   wdata;
    } wb_arb_entry_t;

    // Pointer width that stays at least one bit for single-entry queues.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// DEPTH-entry circular FIFO of LLU write-back entries. The caller never pushes
// when full or pops when empty; pointers wrap by explicit compare.
module wb_arb_fifo
    import core_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push,
    input  wb_arb_entry_t entry,
    input  logic          pop,
    output wb_arb_entry_t head,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = ptr_width(DEPTH);

    wb_arb_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage (always wins) and
// queued LLU results. Define WB_ARB_AGE_HOLD_EN to add the head-age hold term.
module wb_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          pipe_wen_i,
    input  logic [4:0]    pipe_addr_i,
    input  reg_bank_mux_t pipe_bank_i,
    input  logic [31:0]   pipe_wdata_i,
    input  logic          llu_valid_i,
    output logic          llu_ready_o,
    input  logic [4:0]    llu_addr_i,
    input  reg_bank_mux_t llu_bank_i,
    input  logic [31:0]   llu_wdata_i,
    output logic          rf_wen_o,
    output logic [4:0]    rf_addr_o,
    output reg_bank_mux_t rf_bank_o,
    output logic [31:0]   rf_wdata_o,
    output wb_src_t       rf_src_o,
    output logic          hold_o,
    output logic          llu_pending_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Degenerate configurations never accept LLU results.
    localparam bit CFG_OK = (DEPTH >= 1) && (MAX_WAIT >= 1);

    logic [CW-1:0] count, count_next;
    wb_arb_entry_t head, llu_entry;
    logic          empty, bypass, push, pop, full_next, hold_d, hold_q;

    assign llu_entry = '{addr: llu_addr_i, bank: llu_bank_i, wdata: llu_wdata_i};

    assign empty       = (count == '0);
    assign llu_ready_o = CFG_OK && (count < CW'(DEPTH));
    assign bypass      = empty && !pipe_wen_i && llu_valid_i;
    assign pop         = !empty && !pipe_wen_i;
    assign push        = llu_valid_i && llu_ready_o && !bypass;
    assign count_next  = count + CW'(push) - CW'(pop);
    assign full_next   = (count_next == CW'(DEPTH));

    wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (push),
        .entry   (llu_entry),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    always_comb begin
        rf_wen_o   = pipe_wen_i;
        rf_src_o   = WB_SRC_PIPE;
        rf_addr_o  = pipe_addr_i;
        rf_bank_o  = pipe_bank_i;
        rf_wdata_o = pipe_wdata_i;
        if (pop) begin
            rf_wen_o   = 1'b1;
            rf_src_o   = WB_SRC_LLU;
            rf_addr_o  = head.addr;
            rf_bank_o  = head.bank;
            rf_wdata_o = head.wdata;
        end else if (bypass) begin
            rf_wen_o   = 1'b1;
            rf_src_o   = WB_SRC_LLU;
            rf_addr_o  = llu_addr_i;
            rf_bank_o  = llu_bank_i;
            rf_wdata_o = llu_wdata_i;
        end
    end

`ifdef WB_ARB_AGE_HOLD_EN
    localparam int unsigned AW = $clog2(MAX_WAIT + 1);

    logic [AW-1:0] age_q, age_d;

    // Age counts cycles the head sits unserved; a pop restarts it.
    always_comb begin
        age_d = age_q;
        if (pop)
            age_d = '0;
        else if (!empty && (age_q < AW'(MAX_WAIT)))
            age_d = age_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) age_q <= '0;
        else          age_q <= age_d;
    end

    assign hold_d = full_next || (age_d >= AW'(MAX_WAIT));
`else
    assign hold_d = full_next;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) hold_q <= 1'b0;
        else          hold_q <= hold_d;
    end

    assign hold_o        = hold_q;
    assign llu_pending_o = !empty;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, hand sequences for the
// multi-cycle corners, and a randomized run against a queue-based model.
module tb_wb_port_arbiter;
    import core_pkg::*;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 8;
`ifdef WB_ARB_AGE_HOLD_EN
    localparam bit AGE_ON = 1'b1;
`else
    localparam bit AGE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pipe_wen, llu_valid, llu_ready;
    logic [4:0]    pipe_addr, llu_addr, rf_addr;
    reg_bank_mux_t pipe_bank, llu_bank, rf_bank;
    logic [31:0]   pipe_wdata, llu_wdata, rf_wdata;
    logic          rf_wen, hold, llu_pending;
    wb_src_t       rf_src;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .pipe_wen_i    (pipe_wen),
        .pipe_addr_i   (pipe_addr),
        .pipe_bank_i   (pipe_bank),
        .pipe_wdata_i  (pipe_wdata),
        .llu_valid_i   (llu_valid),
        .llu_ready_o   (llu_ready),
        .llu_addr_i    (llu_addr),
        .llu_bank_i    (llu_bank),
        .llu_wdata_i   (llu_wdata),
        .rf_wen_o      (rf_wen),
        .rf_addr_o     (rf_addr),
        .rf_bank_o     (rf_bank),
        .rf_wdata_o    (rf_wdata),
        .rf_src_o      (rf_src),
        .hold_o        (hold),
        .llu_pending_o (llu_pending)
    );

    typedef struct {
        logic        pw; logic [4:0] pa; logic pb; logic [31:0] pd;
        logic        lv; logic [4:0] la; logic lb; logic [31:0] ld;
        logic        ew; logic [4:0] ea; logic eb; logic [31:0] ed; logic es;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic w, input logic [4:0] a, input logic b, input logic [31:0] d);
        pipe_wen = w; pipe_addr = a; pipe_bank = reg_bank_mux_t'(b); pipe_wdata = d;
    endtask

    task automatic set_llu(input logic v, input logic [4:0] a, input logic b, input logic [31:0] d);
        llu_valid = v; llu_addr = a; llu_bank = reg_bank_mux_t'(b); llu_wdata = d;
    endtask

    task automatic chk_write(input string name, input logic [4:0] a, input logic b,
                             input logic [31:0] d, input logic src);
        chk({name, "_wen"}, rf_wen, 1'b1);
        chk({name, "_src"}, rf_src, src);
        chk({name, "_data"}, {rf_addr, rf_bank, rf_wdata}, {a, b, d});
    endtask

    // Reference model: queue of pending entries, head age, registered hold.
    logic [37:0] q[$];
    int          m_age;
    bit          m_hold;

    task automatic model_reset();
        q.delete();
        m_age  = 0;
        m_hold = 1'b0;
    endtask

    initial begin
        int  k_exp;
        bit  accepted;
        int  prob;

        vecs[0] = '{1'b1, 5'd5,  1'b0, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'h0,
                    1'b1, 5'd5,  1'b0, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b0, 5'd1,  1'b0, 32'h0,        1'b1, 5'd7, 1'b0, 32'h12345678,
                    1'b1, 5'd7,  1'b0, 32'h12345678, 1'b1};
        vecs[2] = '{1'b1, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0, 5'd4, 1'b0, 32'h5,
                    1'b1, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{1'b0, 5'd2,  1'b0, 32'h1,        1'b1, 5'd0, 1'b1, 32'h0,
                    1'b1, 5'd0,  1'b1, 32'h0,        1'b1};
        vecs[4] = '{1'b0, 5'd4,  1'b1, 32'hCAFE,     1'b0, 5'd9, 1'b0, 32'h9,
                    1'b0, 5'd0,  1'b0, 32'h0,        1'b0};

        rst_n = 1'b0;
        set_pipe(1'b0, 5'd0, 1'b0, 32'h0);
        set_llu(1'b0, 5'd0, 1'b0, 32'h0);
        #3;
        chk("reset_outputs", {rf_wen, rf_src, hold, llu_ready, llu_pending},
            {1'b0, WB_SRC_PIPE, 1'b0, 1'b1, 1'b0});
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single-cycle vectors from an empty FIFO; none of them enqueue.
        for (int i = 0; i < 5; i++) begin
            set_pipe(vecs[i].pw, vecs[i].pa, vecs[i].pb, vecs[i].pd);
            set_llu(vecs[i].lv, vecs[i].la, vecs[i].lb, vecs[i].ld);
            #2;
            chk($sformatf("vec%0d_wen", i), rf_wen, vecs[i].ew);
            chk($sformatf("vec%0d_src", i), rf_src, vecs[i].es);
            if (vecs[i].ew)
                chk($sformatf("vec%0d_data", i), {rf_addr, rf_bank, rf_wdata},
                    {vecs[i].ea, vecs[i].eb, vecs[i].ed});
            cyc();
            set_llu(1'b0, 5'd0, 1'b0, 32'h0);
            #1;
            chk($sformatf("vec%0d_empty", i), {llu_pending, llu_ready}, 2'b01);
            cyc();
        end

        // Conflict: pipe wins, LLU entry drains on the next idle cycle.
        set_pipe(1'b1, 5'd3, 1'b0, 32'hAAAA0003);
        set_llu(1'b1, 5'd9, 1'b1, 32'hBBBB0009);
        #2;
        chk_write("conflict_pipe", 5'd3, 1'b0, 32'hAAAA0003, 1'b0);
        cyc();
        set_pipe(1'b0, 5'd0, 1'b0, 32'h0);
        set_llu(1'b0, 5'd0, 1'b0, 32'h0);
        #2;
        chk("conflict_pending", llu_pending, 1'b1);
        chk_write("conflict_drain", 5'd9, 1'b1, 32'hBBBB0009, 1'b1);
        cyc();
        #2;
        chk("conflict_idle", {rf_wen, llu_pending}, 2'b00);

        // Full hold: two pushes under continuous pipe writes.
        set_pipe(1'b1, 5'd1, 1'b0, 32'h11);
        set_llu(1'b1, 5'd10, 1'b0, 32'h1000000A);
        cyc();
        set_llu(1'b1, 5'd11, 1'b1, 32'h1000000B);
        #2;
        chk("full_ready_mid", {llu_ready, hold}, 2'b10);
        cyc();
        set_llu(1'b0, 5'd0, 1'b0, 32'h0);
        #2;
        chk("full_ready_low", llu_ready, 1'b0);
        chk("full_hold_high", hold, 1'b1);
        chk_write("full_pipe_still", 5'd1, 1'b0, 32'h11, 1'b0);
        cyc();
        set_pipe(1'b0, 5'd0, 1'b0, 32'h0);
        #2;
        chk_write("full_pop0", 5'd10, 1'b0, 32'h1000000A, 1'b1);
        chk("full_hold_at_pop0", hold, 1'b1);
        cyc();
        #2;
        chk_write("full_pop1", 5'd11, 1'b1, 32'h1000000B, 1'b1);
        chk("full_hold_cleared", hold, 1'b0);
        cyc();
        #2;
        chk("full_drained", {rf_wen, llu_pending, llu_ready}, 3'b001);

        // Age hold: one entry starved by continuous pipe writes.
        set_pipe(1'b1, 5'd2, 1'b0, 32'h22);
        set_llu(1'b1, 5'd12, 1'b0, 32'hC0C0000C);
        cyc();
        set_llu(1'b0, 5'd0, 1'b0, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            #2;
            k_exp = (AGE_ON && k >= MAX_WAIT + 1) ? 1 : 0;
            chk($sformatf("age_hold_k%0d", k), hold, k_exp[0]);
            cyc();
        end
        set_pipe(1'b0, 5'd0, 1'b0, 32'h0);
        #2;
        chk_write("age_drain", 5'd12, 1'b0, 32'hC0C0000C, 1'b1);
        cyc();
        #2;
        chk("age_after_drain", {hold, llu_pending}, 2'b00);

        // Reset while two entries are queued.
        set_pipe(1'b1, 5'd6, 1'b0, 32'h66);
        set_llu(1'b1, 5'd20, 1'b0, 32'h20);
        cyc();
        set_llu(1'b1, 5'd21, 1'b1, 32'h21);
        cyc();
        set_pipe(1'b0, 5'd0, 1'b0, 32'h0);
        set_llu(1'b0, 5'd0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_outputs", {rf_wen, rf_src, hold, llu_ready, llu_pending},
            {1'b0, WB_SRC_PIPE, 1'b0, 1'b1, 1'b0});
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("rstmid_nowrite%0d", k), {rf_wen, llu_pending}, 2'b00);
            cyc();
        end

        // Randomized run against the queue model.
        model_reset();
        set_llu(1'b0, 5'd0, 1'b0, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            logic        exp_wen, exp_src, exp_ready, popped, bypassed;
            logic [37:0] exp_ent, llu_ent;
            int          size;

            prob = (n < 1000) ? 3 : (n < 2000) ? 6 : 9;
            if (!llu_valid && $urandom_range(0, 9) < 4)
                set_llu(1'b1, 5'($urandom), 1'($urandom), $urandom);
            set_pipe($urandom_range(0, 9) < prob, 5'($urandom), 1'($urandom), $urandom);
            #2;
            size      = q.size();
            exp_ready = (size < DEPTH);
            llu_ent   = {llu_addr, llu_bank, llu_wdata};
            popped    = 1'b0;
            bypassed  = 1'b0;
            exp_wen   = 1'b1;
            exp_src   = 1'b0;
            exp_ent   = {pipe_addr, pipe_bank, pipe_wdata};
            if (!pipe_wen) begin
                if (size > 0) begin
                    exp_src = 1'b1; exp_ent = q[0]; popped = 1'b1;
                end else if (llu_valid) begin
                    exp_src = 1'b1; exp_ent = llu_ent; bypassed = 1'b1;
                end else begin
                    exp_wen = 1'b0;
                end
            end
            chk("rand_ctl", {llu_ready, hold, llu_pending, rf_wen, rf_src},
                {exp_ready, m_hold, size > 0, exp_wen, exp_src});
            if (exp_wen)
                chk("rand_data", {rf_addr, rf_bank, rf_wdata}, exp_ent);

            accepted = llu_valid && (bypassed || exp_ready);
            if (popped) void'(q.pop_front());
            if (accepted && !bypassed) q.push_back(llu_ent);
            if (popped) m_age = 0;
            else if (size > 0 && m_age < MAX_WAIT) m_age++;
            m_hold = (q.size() == DEPTH) || (AGE_ON && m_age >= MAX_WAIT);

            cyc();
            if (accepted) set_llu(1'b0, 5'd0, 1'b0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline WB stage and a long-latency unit (LLU: iterative divider or FPU) that completes out of order. The pipeline always wins the port. LLU results queue in a small FIFO and drain on idle WB cycles. Queue pressure or age raises a registered hold request, so core control inserts a WB bubble. Sits between the WB stage outputs, the LLU result interface and the register banks (X_REG/F_REG).

## Interface
- DEPTH, 2: LLU result FIFO entries (≥1).
- MAX_WAIT, 8: cycles the FIFO head may wait before hold is requested (≥1).

Reset and clock (already decided): reset rst_n_i, asynchronous, active-low; clock clk_i.

- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- pipe_wen_i  in  1  WB stage write request (reg_wen of WB)
- pipe_addr_i  in  5  WB rd address
- pipe_bank_i  in  reg_bank_mux_t  WB destination bank
- pipe_wdata_i  in  32  WB write data
- llu_valid_i  in  1  LLU result valid
- llu_ready_o  out  1  FIFO can accept
- llu_addr_i  in  5  LLU rd address
- llu_bank_i  in  reg_bank_mux_t  LLU destination bank
- llu_wdata_i  in  32  LLU result
- rf_wen_o  out  1  register-file write enable
- rf_addr_o  out  5  write address
- rf_bank_o  out  reg_bank_mux_t  write bank
- rf_wdata_o  out  32  write data
- rf_src_o  out  wb_src_t  source of current write
- hold_o  out  1  registered request: core flushes MEM→WB next edge
- llu_pending_o  out  1  FIFO non-empty

## Operation
- Grant: pipe_wen_i=1 → pipeline drives rf_*, rf_src_o=WB_SRC_PIPE. Otherwise, a non-empty FIFO pops its head onto rf_*, rf_src_o=WB_SRC_LLU.
- Bypass: FIFO empty, pipe_wen_i=0 and llu_valid_i=1 → LLU result is written in the same cycle. It is not pushed.
- Push: llu_valid_i && llu_ready_o, not bypassed → entry enqueued at tail.
- llu_ready_o = (count < DEPTH), computed from the registered count. A same-cycle pop does not raise it.
- LLU holds valid/data stable until accepted. Acceptance means a push or a bypass.
- Push and pop in the same cycle are both performed; count is unchanged.
- Age counter: increments each cycle the FIFO is non-empty and no pop occurs. It saturates at MAX_WAIT and clears on pop.
- hold_o next = (count==DEPTH) || (age>=MAX_WAIT), evaluated on post-update state. It clears the cycle after the condition drops.
- Idle output: rf_wen_o=0. rf_addr_o, rf_bank_o and rf_wdata_o then mirror the pipeline inputs; they are don't-care.
- No WAW resolution: the scoreboard guarantees the pipeline never writes an rd/bank that is pending in the FIFO.
- Reset: FIFO empty, age=0, hold_o=0, llu_ready_o=1 (DEPTH≥1), llu_pending_o=0, rf_wen_o=0, rf_src_o=WB_SRC_PIPE.

## Timing
- Pipeline write: 0 cycles (combinational pass-through).
- LLU bypass: 0 cycles. Queued LLU entry: written on the first cycle with pipe_wen_i=0 after push.
- Hold sequence:
  - Condition true in cycle t → hold_o=1 from edge t+1.
  - Core asserts flush_wb during cycle t+1.
  - pipe_wen_i=0 in cycle t+2 → head drains.
  - Worst-case drain is 2 cycles after the condition.
- The pipeline may still write in the cycle where hold_o first rises.
- FIFO pointers wrap modulo DEPTH. With DEPTH non-power-of-two, wrap is an explicit compare.
- Reset mid-operation discards queued results; the LLU is reset by the same rst_n_i.

## Configuration
- WB_ARB_AGE_HOLD_EN defined: age counter is present and hold_o includes the age>=MAX_WAIT term.
- Undefined: no age counter and MAX_WAIT is ignored. hold_o = registered (count==DEPTH) only, so starvation is bounded only by pipeline idle cycles.

## Structure
- core_pkg gains:
  - wb_src_t {WB_SRC_PIPE, WB_SRC_LLU}.
  - typedef wb_arb_entry_t {addr[4:0], bank reg_bank_mux_t, wdata[31:0]}.
- Existing reg_bank_mux_t is reused.
- Sub-module wb_arb_fifo: DEPTH-entry circular FIFO of wb_arb_entry_t with push, pop, count, head.
- Grant and mux logic, age counter and hold register live in the top level.

## Test plan
- Pipeline only: pipe_wen_i=1, addr=5, data=0xDEADBEEF, llu_valid_i=0 → rf_wen_o=1, rf_addr_o=5, src=PIPE same cycle; FIFO stays empty.
- Bypass: pipe idle, llu_valid_i=1, addr=7, data=0x12345678 → written same cycle, src=LLU; llu_pending_o stays 0.
- Conflict: pipe_wen_i=1 (addr 3) and LLU valid (addr 9) → pipe writes addr 3. Next idle cycle writes addr 9 from the FIFO.
- Full hold (DEPTH=2): pipe_wen_i=1 continuously; LLU pushes addr 10, then 11.
  - llu_ready_o=0 after the second push; hold_o=1 the next cycle.
  - After bench drops pipe_wen_i: addr 10, then addr 11 written in order.
  - hold_o clears after the first pop.
- Age hold (macro on, MAX_WAIT=8): one entry queued, pipe_wen_i=1 continuously → hold_o rises 9 cycles after push.
  - Macro off: hold_o stays 0.
- Reset mid-queue: two entries queued, rst_n_i pulsed low → all outputs at reset values; no write of the queued data after release.
